fifo_word_packer: RTL and testbench
===================================

// Module: fifo_word_packer
// PURPOSE
//  Read-side consumer of the async FIFO. Runs in the rclk domain.
//  Pops DSIZE-bit bytes from the FIFO read port and packs NBYTES of them into one output word.
//  Presents each word on a valid/ready stream to the next stage.
//  A word that is only partly filled is released early on an explicit flush or after an idle timeout.
// PARAMETERS
//  DSIZE    8   width of one FIFO entry (byte lane)
//  NBYTES   4   lanes per output word; legal range 2..8
//  TIMEOUT  16  idle rclk cycles before a partial word is force-released; 0 disables the timeout
// PORTS
//  rclk        in   1              the only clock; all state updates on its rising edge
//  rrst_n      in   1              asynchronous, active-low reset
//  fifo_rdata  in   DSIZE          FIFO head entry; first-word-fall-through, valid whenever fifo_empty=0
//  fifo_empty  in   1              FIFO empty flag (rclk domain)
//  fifo_rinc   out  1              pop strobe; the FIFO head advances at the next rclk edge
//  flush       in   1              single-cycle request to release the current partial word
//  out_data    out  DSIZE*NBYTES   packed word; first popped byte sits in lane 0 ([DSIZE-1:0])
//  out_keep    out  NBYTES         lane-valid mask; always contiguous from lane 0
//  out_valid   out  1              output word valid
//  out_ready   in   1              downstream accepts the word when out_valid && out_ready
// BEHAVIOUR
//  Reset (async, rrst_n=0): out_valid=0, out_data=0, out_keep=0, cnt=0, flush_pend=0, idle=0.
//   fifo_rinc is combinational and is 0 while in reset.
//  State: accumulator acc[NBYTES lanes], fill count cnt (0..NBYTES), flush_pend, idle counter,
//   and the output register (out_data/out_keep/out_valid).
//  Definitions:
//   out_free = !out_valid || out_ready
//   full_x   = (cnt==NBYTES) && out_free
//   part_x   = flush_pend && (cnt>0) && (cnt<NBYTES) && out_free
//   pop      = !fifo_empty && ((cnt<NBYTES && !part_x) || full_x)
//   fifo_rinc = pop  (combinational, no registered stage)
//  On pop: fifo_rdata is written into lane (full_x ? 0 : cnt).
//  On full_x or part_x:
//   out_data <= acc, with unused lanes zeroed; out_keep <= (1<<cnt)-1; out_valid <= 1.
//   cnt <= pop ? 1 : 0; flush_pend <= 0; idle <= 0.
//  Otherwise: cnt <= cnt + pop.
//   out_valid clears on out_ready when no transfer happens in the same cycle.
//  Throughput: 1 byte per rclk with no bubble across word boundaries while out_ready=1.
//   Latency: the 4th pop at edge k gives out_valid=1 after edge k+1.
//  flush: sets flush_pend when cnt>0 or a pop occurs in the same cycle; otherwise it is ignored.
//   flush while cnt==NBYTES: the full word releases normally and flush_pend stays set for the next partial.
//  Timeout: idle increments each cycle with cnt>0, !pop and !flush_pend.
//   idle clears on any pop.
//   When idle reaches TIMEOUT-1, flush_pend is set.
//  Backpressure: out_valid && !out_ready holds out_data/out_keep stable.
//   The accumulator keeps filling up to NBYTES and then stops popping (fifo_rinc=0).
//  fifo_empty=1: no pop; the accumulator holds its contents.
//  Never pops when fifo_empty=1; never drops or duplicates a byte.
//  Reset mid-word: the accumulator contents are discarded; no partial word is emitted.
// STRUCTURE
//  Shared include fifo_defs.vh: DSIZE default and NBYTES default;
//   KEEP_ALL = {NBYTES{1'b1}}; function clog2 for sizing cnt and idle.
//  One sub-module: packer_idle_timer (TIMEOUT counter, clear/enable in, expire pulse out).
//  Packing datapath and output register stay inline.
// TESTING
//  1 Reset: hold rrst_n=0, fifo_empty=0 -> fifo_rinc=0, out_valid=0, out_keep=0.
//  2 Stream: FIFO holds 11,22,33,44,55,66,77,88, out_ready=1
//    -> words 0x44332211 then 0x88776655, keep=4'hF, fifo_rinc high 8 consecutive cycles.
//  3 Partial via flush: pop AA,BB, then fifo_empty=1 and flush pulse
//    -> out_data=0x0000BBAA, keep=4'h3, next pop lands in lane 0.
//  4 Timeout: pop CC, then fifo_empty=1 for 20 cycles, TIMEOUT=16
//    -> out_valid 17 cycles after the pop, data=0x000000CC, keep=4'h1.
//  5 Backpressure: out_ready=0 with 12 bytes available
//    -> first word held stable, exactly 8 pops then fifo_rinc=0;
//       release out_ready -> remaining words in order, none lost.
//  6 Reset mid-word: 2 bytes accumulated, pulse rrst_n low
//    -> no output; next 4 bytes form a fresh word starting at lane 0.

Source files
------------

// File: rtl/fifo_word_packer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_word_packer_pkg: sizing defaults, word-release kinds and clog2 helper.
// Rev 1.0
// ---------------------------------------------------------------------------
package fifo_word_packer_pkg;

  localparam int DSIZE_DEF  = 8;
  localparam int NBYTES_DEF = 4;

  typedef enum logic [1:0] {
    REL_NONE = 2'd0,
    REL_FULL = 2'd1,
    REL_PART = 2'd2
  } rel_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_word_packer_idle_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// packer_idle_timer: counts idle cycles and pulses expire at TIMEOUT-1.
// Rev 1.0
// ---------------------------------------------------------------------------
module packer_idle_timer
  import fifo_word_packer_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic rclk,
  input  logic rrst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int IW = (TIMEOUT > 1) ? clog2(TIMEOUT) : 1;

  logic [IW-1:0] idle_q, idle_d;
  logic          hit;

  generate
    if (TIMEOUT == 0) begin : g_disabled
      assign hit = 1'b0;
    end else begin : g_enabled
      assign hit = (idle_q == IW'(TIMEOUT - 1));
    end
  endgenerate

  // A clear in the same cycle wins: a pop or release makes the word non-idle.
  assign expire = en && !clr && hit;

  always_comb begin
    idle_d = idle_q;
    if (clr || expire) idle_d = '0;
    else if (en)       idle_d = idle_q + 1'b1;
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) idle_q <= '0;
    else         idle_q <= idle_d;
  end

endmodule
`default_nettype wire

// File: rtl/fifo_word_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_word_packer: pops FIFO bytes and packs them into valid/ready words.
// Rev 1.0
// ---------------------------------------------------------------------------
module fifo_word_packer
  import fifo_word_packer_pkg::*;
#(
  parameter int DSIZE   = DSIZE_DEF,
  parameter int NBYTES  = NBYTES_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic                    rclk,
  input  logic                    rrst_n,
  input  logic [DSIZE-1:0]        fifo_rdata,
  input  logic                    fifo_empty,
  output logic                    fifo_rinc,
  input  logic                    flush,
  output logic [DSIZE*NBYTES-1:0] out_data,
  output logic [NBYTES-1:0]       out_keep,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int                CW       = clog2(NBYTES + 1);
  localparam int                LW       = clog2(NBYTES);
  localparam logic [CW-1:0]     CNT_FULL = CW'(NBYTES);
  localparam logic [NBYTES-1:0] KEEP_ALL = {NBYTES{1'b1}};

  logic [NBYTES-1:0][DSIZE-1:0] acc_q, acc_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic                         flush_pend_q, flush_pend_d;
  logic [DSIZE*NBYTES-1:0]      out_data_q, out_data_d;
  logic [NBYTES-1:0]            out_keep_q, out_keep_d;
  logic                         out_valid_q, out_valid_d;

  logic          out_free;
  logic          full_x;
  logic          part_x;
  logic          pop;
  logic          flush_set;
  logic          tmo_clr;
  logic          tmo_en;
  logic          tmo_expire;
  logic [LW-1:0] wr_lane;
  rel_e          rel;

  assign out_free = !out_valid_q || out_ready;
  assign full_x   = (cnt_q == CNT_FULL) && out_free;
  assign part_x   = flush_pend_q && (cnt_q != '0) && (cnt_q < CNT_FULL) && out_free;
  // Gated by reset so the FIFO never advances while the packer is held.
  assign pop      = rrst_n && !fifo_empty && (((cnt_q < CNT_FULL) && !part_x) || full_x);

  assign fifo_rinc = pop;
  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign out_valid = out_valid_q;

  always_comb begin
    rel = REL_NONE;
    if (full_x)      rel = REL_FULL;
    else if (part_x) rel = REL_PART;
  end

  assign wr_lane = (rel == REL_FULL) ? '0 : cnt_q[LW-1:0];

  assign tmo_clr = pop || (rel != REL_NONE);
  assign tmo_en  = (cnt_q != '0) && !pop && !flush_pend_q;

  packer_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expire (tmo_expire)
  );

  // A request raised in the release cycle survives into the next partial word.
  assign flush_set = (flush && ((cnt_q != '0) || pop)) || tmo_expire;

  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    out_data_d   = out_data_q;
    out_keep_d   = out_keep_q;
    out_valid_d  = out_valid_q;

    case (rel)
      REL_FULL: begin
        out_data_d   = acc_q;
        out_keep_d   = KEEP_ALL;
        out_valid_d  = 1'b1;
        cnt_d        = pop ? CW'(1) : '0;
        flush_pend_d = flush_set;
      end
      REL_PART: begin
        for (int i = 0; i < NBYTES; i++) begin
          out_data_d[i*DSIZE +: DSIZE] = (CW'(i) < cnt_q) ? acc_q[i] : '0;
          out_keep_d[i]                = (CW'(i) < cnt_q);
        end
        out_valid_d  = 1'b1;
        cnt_d        = pop ? CW'(1) : '0;
        flush_pend_d = flush_set;
      end
      default: begin
        if (out_ready) out_valid_d = 1'b0;
        cnt_d        = cnt_q + CW'(pop);
        flush_pend_d = flush_pend_q || flush_set;
      end
    endcase

    if (pop) acc_d[wr_lane] = fifo_rdata;
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
      out_valid_q  <= out_valid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_word_packer.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_fifo_word_packer: directed scenarios plus randomized traffic vs a queue model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_fifo_word_packer;

  localparam int DSIZE   = 8;
  localparam int NBYTES  = 4;
  localparam int TIMEOUT = 16;
  localparam int WW      = DSIZE * NBYTES;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DSIZE-1:0]  fifo_rdata;
  logic              fifo_empty;
  logic              fifo_rinc;
  logic              flush;
  logic [WW-1:0]     out_data;
  logic [NBYTES-1:0] out_keep;
  logic              out_valid;
  logic              out_ready;

  always #5 clk = ~clk;

  fifo_word_packer #(
    .DSIZE   (DSIZE),
    .NBYTES  (NBYTES),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .rclk       (clk),
    .rrst_n     (rst_n),
    .fifo_rdata (fifo_rdata),
    .fifo_empty (fifo_empty),
    .fifo_rinc  (fifo_rinc),
    .flush      (flush),
    .out_data   (out_data),
    .out_keep   (out_keep),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Source FIFO and captured output
  logic [DSIZE-1:0]  src[$];
  logic [DSIZE-1:0]  sent[$];
  logic [DSIZE-1:0]  got_bytes[$];
  logic [WW-1:0]     got_data[$];
  logic [NBYTES-1:0] got_keep[$];
  bit                hold_empty = 1'b0;

  // Behavioural model: bytes waiting in the accumulator plus the output register
  logic [DSIZE-1:0]  m_acc[$];
  bit                m_pend;
  int                m_idle;
  logic [WW-1:0]     m_data;
  logic [NBYTES-1:0] m_keep;
  bit                m_valid;

  int cyc = 0;
  int n_pops = 0;
  int pop_run = 0;
  int pop_run_max = 0;
  int last_pop_cyc = -1;

  task automatic push(input logic [DSIZE-1:0] b);
    src.push_back(b);
    sent.push_back(b);
  endtask

  task automatic clear_capture();
    got_data.delete();
    got_keep.delete();
    got_bytes.delete();
  endtask

  task automatic cycle();
    bit               free, fx, px, pp, rel, en, expire, set_now;
    int               sz;
    logic [DSIZE-1:0] b;
    fifo_empty = hold_empty || (src.size() == 0);
    fifo_rdata = (src.size() != 0) ? src[0] : '0;
    @(negedge clk);
    if (!rst_n) begin
      m_acc.delete();
      m_pend  = 1'b0;
      m_idle  = 0;
      m_data  = '0;
      m_keep  = '0;
      m_valid = 1'b0;
    end
    sz     = m_acc.size();
    free   = !m_valid || out_ready;
    fx     = rst_n && (sz == NBYTES) && free;
    px     = rst_n && m_pend && (sz > 0) && (sz < NBYTES) && free;
    pp     = rst_n && !fifo_empty && (((sz < NBYTES) && !px) || fx);
    rel    = fx || px;
    en     = (sz > 0) && !pp && !m_pend;
    expire = (TIMEOUT != 0) && en && !rel && (m_idle == TIMEOUT - 1);
    set_now = (flush && ((sz > 0) || pp)) || expire;
    b = fifo_rdata;

    check_eq("rinc", fifo_rinc, pp);
    check_eq("valid", out_valid, m_valid);
    check_eq("data", out_data, m_data);
    check_eq("keep", out_keep, m_keep);

    if (fifo_rinc) begin
      n_pops++;
      pop_run++;
      last_pop_cyc = cyc;
      if (pop_run > pop_run_max) pop_run_max = pop_run;
    end else begin
      pop_run = 0;
    end
    if (rst_n && out_valid && out_ready) begin
      got_data.push_back(out_data);
      got_keep.push_back(out_keep);
      for (int i = 0; i < NBYTES; i++)
        if (out_keep[i]) got_bytes.push_back(out_data[i*DSIZE +: DSIZE]);
    end

    @(posedge clk);
    if (rst_n) begin
      if (rel) begin
        m_data = '0;
        for (int i = 0; i < sz; i++) m_data[i*DSIZE +: DSIZE] = m_acc[i];
        m_keep  = NBYTES'((1 << sz) - 1);
        m_valid = 1'b1;
        m_acc.delete();
        m_pend  = set_now;
        m_idle  = 0;
      end else begin
        if (out_ready) m_valid = 1'b0;
        m_pend = m_pend || set_now;
        if (pp || expire) m_idle = 0;
        else if (en)      m_idle++;
      end
      if (pp) begin
        m_acc.push_back(b);
        void'(src.pop_front());
      end
    end
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int vcyc;
    int nbad;
    rst_n      = 1'b0;
    flush      = 1'b0;
    out_ready  = 1'b1;
    fifo_empty = 1'b1;
    fifo_rdata = '0;

    // Reset with data presented: nothing may be popped
    src.push_back(8'h5A);
    run(3);
    check_eq("rst_rinc", fifo_rinc, 1'b0);
    check_eq("rst_valid", out_valid, 1'b0);
    check_eq("rst_keep", out_keep, '0);
    src.delete();
    rst_n = 1'b1;
    run(2);

    // Streaming two full words back to back
    clear_capture();
    pop_run_max = 0;
    for (int i = 1; i <= 8; i++) push(8'(i * 8'h11));
    run(14);
    check_eq("stream_cnt", got_data.size(), 2);
    check_eq("stream_run", pop_run_max, 8);
    if (got_data.size() >= 2) begin
      check_eq("stream_w0", got_data[0], 32'h44332211);
      check_eq("stream_k0", got_keep[0], 4'hF);
      check_eq("stream_w1", got_data[1], 32'h88776655);
      check_eq("stream_k1", got_keep[1], 4'hF);
    end

    // Partial word released by flush, next byte restarts at lane 0
    clear_capture();
    push(8'hAA);
    push(8'hBB);
    run(3);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    run(3);
    push(8'hDD);
    run(2);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    run(3);
    check_eq("flush_cnt", got_data.size(), 2);
    if (got_data.size() >= 2) begin
      check_eq("flush_w0", got_data[0], 32'h0000BBAA);
      check_eq("flush_k0", got_keep[0], 4'h3);
      check_eq("flush_w1", got_data[1], 32'h000000DD);
      check_eq("flush_k1", got_keep[1], 4'h1);
    end

    // Idle timeout releases a single byte
    clear_capture();
    last_pop_cyc = -1;
    push(8'hCC);
    cycle();
    vcyc = -1;
    for (int i = 0; i < 40 && vcyc < 0; i++) begin
      cycle();
      if (out_valid) vcyc = cyc;
    end
    check_eq("tmo_latency", 64'(vcyc - (last_pop_cyc + 1)), 64'd17);
    run(2);
    check_eq("tmo_cnt", got_data.size(), 1);
    if (got_data.size() >= 1) begin
      check_eq("tmo_w0", got_data[0], 32'h000000CC);
      check_eq("tmo_k0", got_keep[0], 4'h1);
    end

    // Backpressure: one word held, accumulator fills, then popping stops
    clear_capture();
    n_pops = 0;
    out_ready = 1'b0;
    for (int i = 1; i <= 12; i++) push(8'(i));
    run(20);
    check_eq("bp_pops", n_pops, 8);
    check_eq("bp_left", src.size(), 4);
    check_eq("bp_rinc", fifo_rinc, 1'b0);
    check_eq("bp_hold", out_data, 32'h04030201);
    out_ready = 1'b1;
    run(20);
    check_eq("bp_cnt", got_data.size(), 3);
    if (got_data.size() >= 3) begin
      check_eq("bp_w0", got_data[0], 32'h04030201);
      check_eq("bp_w1", got_data[1], 32'h08070605);
      check_eq("bp_w2", got_data[2], 32'h0C0B0A09);
    end

    // Reset mid-word discards the partial accumulator
    clear_capture();
    push(8'hE1);
    push(8'hE2);
    run(3);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    run(25);
    check_eq("rstmid_none", got_data.size(), 0);
    push(8'hF1);
    push(8'hF2);
    push(8'hF3);
    push(8'hF4);
    run(8);
    check_eq("rstmid_cnt", got_data.size(), 1);
    if (got_data.size() >= 1) begin
      check_eq("rstmid_w0", got_data[0], 32'hF4F3F2F1);
      check_eq("rstmid_k0", got_keep[0], 4'hF);
    end

    // Randomized traffic with stalls, flushes and idle gaps
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    clear_capture();
    sent.delete();
    src.delete();
    for (int i = 0; i < 3000; i++) begin
      if ((i % 200) < 160 && src.size() < 16 && $urandom_range(0, 1) == 1)
        push(8'($urandom));
      hold_empty = ($urandom_range(0, 7) == 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 40) == 0);
      cycle();
    end
    hold_empty = 1'b0;
    out_ready  = 1'b1;
    flush      = 1'b0;
    run(80);
    check_eq("rand_len", got_bytes.size(), sent.size());
    nbad = 0;
    for (int i = 0; i < sent.size() && i < got_bytes.size(); i++)
      if (got_bytes[i] !== sent[i]) nbad++;
    check_eq("rand_order", nbad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
